// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter: grants one AR/R transaction at a time to icache (m0) or memory stage (m1).
// Optional build macro AXI_RD_ARB_RR_EN selects round-robin arbitration instead of fixed m1-over-m0 priority.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int AR_W       = ADDR_WIDTH + 13,
    parameter int R_W        = DATA_WIDTH + 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AR_W-1:0] m0_ar,
    input  logic            m0_arvalid,
    output logic            m0_arready,
    output logic [R_W-1:0]  m0_r,
    output logic            m0_rvalid,
    input  logic            m0_rready,
    input  logic [AR_W-1:0] m1_ar,
    input  logic            m1_arvalid,
    output logic            m1_arready,
    output logic [R_W-1:0]  m1_r,
    output logic            m1_rvalid,
    input  logic            m1_rready,
    output logic [AR_W-1:0] s_ar,
    output logic            s_arvalid,
    input  logic            s_arready,
    input  logic [R_W-1:0]  s_r,
    input  logic            s_rvalid,
    output logic            s_rready,
    output logic [1:0]      grant,
    output logic            busy,
    output logic            proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  gnt_q;
    logic [7:0]  beat_q;
    logic [7:0]  beat_d;
    logic [7:0]  len_q;
    logic        proto_err_q;
    logic [1:0]  pick_d;
    logic        ar_hs_s;
    logic        r_hs_s;
`ifdef AXI_RD_ARB_RR_EN
    logic        last_owner_q;
`endif

    // Choose the next owner from the pending AR requests.
    always_comb begin
        pick_d = 2'b00;
`ifdef AXI_RD_ARB_RR_EN
        if (m1_arvalid && m0_arvalid) begin
            pick_d = last_owner_q ? 2'b01 : 2'b10;
        end else if (m1_arvalid) begin
            pick_d = 2'b10;
        end else if (m0_arvalid) begin
            pick_d = 2'b01;
        end else begin
            pick_d = 2'b00;
        end
`else
        if (m1_arvalid) begin
            pick_d = 2'b10;
        end else if (m0_arvalid) begin
            pick_d = 2'b01;
        end else begin
            pick_d = 2'b00;
        end
`endif
    end

    // Route AR and R between the granted master and the slave.
    always_comb begin
        s_ar       = '0;
        s_arvalid  = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_r       = '0;
        m0_rvalid  = 1'b0;
        m1_r       = '0;
        m1_rvalid  = 1'b0;
        s_rready   = 1'b0;
        case (state_q)
            ADDR: begin
                if (gnt_q[1]) begin
                    s_ar       = m1_ar;
                    s_arvalid  = m1_arvalid;
                    m1_arready = s_arready;
                end else if (gnt_q[0]) begin
                    s_ar       = m0_ar;
                    s_arvalid  = m0_arvalid;
                    m0_arready = s_arready;
                end else begin
                    s_arvalid  = 1'b0;
                end
            end
            DATA: begin
                if (gnt_q[1]) begin
                    m1_r      = s_r;
                    m1_rvalid = s_rvalid;
                    s_rready  = m1_rready;
                end else if (gnt_q[0]) begin
                    m0_r      = s_r;
                    m0_rvalid = s_rvalid;
                    s_rready  = m0_rready;
                end else begin
                    s_rready  = 1'b0;
                end
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

    // Handshake strobes and saturating beat increment.
    always_comb begin
        ar_hs_s = s_arvalid & s_arready;
        r_hs_s  = s_rvalid & s_rready;
        if (beat_q == 8'hFF) begin
            beat_d = beat_q;
        end else begin
            beat_d = beat_q + 8'd1;
        end
    end

    // Transaction FSM with grant, beat counter and sticky protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            beat_q       <= 8'd0;
            len_q        <= 8'd0;
            proto_err_q  <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_d != 2'b00) begin
                        gnt_q        <= pick_d;
                        state_q      <= ADDR;
`ifdef AXI_RD_ARB_RR_EN
                        last_owner_q <= pick_d[1];
`endif
                    end
                end
                ADDR: begin
                    if (ar_hs_s) begin
                        len_q   <= s_ar[10:3];
                        beat_q  <= 8'd0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs_s) begin
                        beat_q <= beat_d;
                        if (s_r[0]) begin
                            state_q <= IDLE;
                            gnt_q   <= 2'b00;
                            if (beat_q != len_q) begin
                                proto_err_q <= 1'b1;
                            end
                        end else if (beat_q == len_q) begin
                            // Burst overran its length; keep waiting for rlast.
                            proto_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign grant     = busy ? gnt_q : 2'b00;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter; expectations follow AXI_RD_ARB_RR_EN when defined.
module tb_axi_rd_arbiter;

    localparam int AR_W = 45;
    localparam int R_W  = 67;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AR_W-1:0] m0_ar, m1_ar, s_ar;
    logic            m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [R_W-1:0]  m0_r, m1_r, s_r;
    logic            m0_rvalid, m0_rready, m1_rvalid, m1_rready;
    logic            s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]      grant;
    logic            busy, proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_ar(m0_ar), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_r(m0_r), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_ar(m1_ar), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_r(m1_r), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_ar(s_ar), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_r(s_r), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AR_W-1:0] mk_ar(input logic [31:0] a, input logic [7:0] len);
        return {a, 2'b01, len, 3'b011};
    endfunction

    function automatic logic [R_W-1:0] mk_r(input logic [63:0] d, input logic last);
        return {d, 2'b00, last};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        m0_ar = '0; m0_arvalid = 1'b0; m0_rready = 1'b0;
        m1_ar = '0; m1_arvalid = 1'b0; m1_rready = 1'b0;
        s_arready = 1'b0; s_r = '0; s_rvalid = 1'b0;
    endtask

    // Request from one master and complete the AR handshake; returns in the first DATA cycle.
    task automatic start_rd(input bit use_m1, input logic [AR_W-1:0] ar);
        if (use_m1) begin
            m1_ar = ar; m1_arvalid = 1'b1;
        end else begin
            m0_ar = ar; m0_arvalid = 1'b1;
        end
        cyc();
        s_arready = 1'b1;
        cyc();
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_arready = 1'b0;
    endtask

    bit       pat [3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0] rr_exp [6];

    initial begin
        clr();
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_s_arvalid", s_arvalid, 1'b0);
        check("rst_s_rready", s_rready, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        cyc();
        rst = 1'b0;

        // Single m0 read, len=3, slave arready delayed two cycles.
        cyc();
        m0_ar = mk_ar(32'h8000_0000, 8'd3); m0_arvalid = 1'b1;
        #2;
        check("t1_idle_arready", m0_arready, 1'b0);
        check("t1_idle_s_arvalid", s_arvalid, 1'b0);
        cyc(); #2;
        check("t1_grant", grant, 2'b01);
        check("t1_busy", busy, 1'b1);
        check("t1_s_arvalid", s_arvalid, 1'b1);
        check("t1_s_ar", s_ar, mk_ar(32'h8000_0000, 8'd3));
        check("t1_arready_wait", m0_arready, 1'b0);
        cyc();
        s_arready = 1'b1;
        #2;
        check("t1_m0_arready", m0_arready, 1'b1);
        check("t1_m1_arready", m1_arready, 1'b0);
        cyc();
        m0_arvalid = 1'b0; s_arready = 1'b0; m0_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_rvalid = 1'b1;
            s_r = mk_r(64'hA0 + 64'(i), (i == 3));
            #2;
            check("t1_m0_rvalid", m0_rvalid, 1'b1);
            check("t1_m0_r", m0_r, mk_r(64'hA0 + 64'(i), (i == 3)));
            check("t1_m1_rvalid", m1_rvalid, 1'b0);
            check("t1_data_s_arvalid", s_arvalid, 1'b0);
            check("t1_data_busy", busy, 1'b1);
            cyc();
        end
        clr();
        #2;
        check("t1_end_busy", busy, 1'b0);
        check("t1_end_grant", grant, 2'b00);
        check("t1_end_perr", proto_err, 1'b0);

        // Simultaneous requests, len=0: m1 first, then m0 after one IDLE cycle.
        cyc();
        m0_ar = mk_ar(32'h8000_0100, 8'd0); m1_ar = mk_ar(32'h8000_1000, 8'd0);
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1;
        cyc(); #2;
        check("t2_grant_a", grant, 2'b10);
        check("t2_s_ar_a", s_ar, mk_ar(32'h8000_1000, 8'd0));
        check("t2_m1_arready", m1_arready, 1'b1);
        check("t2_m0_arready_a", m0_arready, 1'b0);
        cyc();
        m1_arvalid = 1'b0; s_rvalid = 1'b1; s_r = mk_r(64'h1111, 1'b1);
        #2;
        check("t2_data_s_arvalid", s_arvalid, 1'b0);
        check("t2_data_m0_arready", m0_arready, 1'b0);
        check("t2_m1_r", m1_r, mk_r(64'h1111, 1'b1));
        check("t2_m0_rvalid_a", m0_rvalid, 1'b0);
        check("t2_m0_r_a", m0_r, {R_W{1'b0}});
        cyc();
        s_rvalid = 1'b0;
        #2;
        check("t2_gap_busy", busy, 1'b0);
        check("t2_gap_m0_arready", m0_arready, 1'b0);
        cyc(); #2;
        check("t2_grant_b", grant, 2'b01);
        check("t2_s_ar_b", s_ar, mk_ar(32'h8000_0100, 8'd0));
        cyc();
        m0_arvalid = 1'b0; s_rvalid = 1'b1; s_r = mk_r(64'h2222, 1'b1);
        #2;
        check("t2_m0_rvalid_b", m0_rvalid, 1'b1);
        check("t2_m1_rvalid_b", m1_rvalid, 1'b0);
        cyc();
        clr();
        #2;
        check("t2_end_busy", busy, 1'b0);
        check("t2_end_perr", proto_err, 1'b0);

        // R backpressure on m1, len=1.
        start_rd(1'b1, mk_ar(32'h0000_2000, 8'd1));
        s_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m1_rready = pat[i];
            s_r = mk_r(64'hB0 + 64'(i), (i == 2));
            #2;
            check("t3_s_rready", s_rready, pat[i]);
            check("t3_m0_rvalid", m0_rvalid, 1'b0);
            check("t3_busy", busy, 1'b1);
            cyc();
        end
        clr();
        #2;
        check("t3_end_busy", busy, 1'b0);
        check("t3_end_perr", proto_err, 1'b0);

        // Early rlast: len=3 but last on beat 2.
        start_rd(1'b0, mk_ar(32'h0000_3000, 8'd3));
        m0_rready = 1'b1; s_rvalid = 1'b1; s_r = mk_r(64'hC0, 1'b0);
        cyc();
        s_r = mk_r(64'hC1, 1'b1);
        #2;
        check("t4_perr_before", proto_err, 1'b0);
        cyc();
        clr();
        #2;
        check("t4_perr_set", proto_err, 1'b1);
        check("t4_idle", busy, 1'b0);
        cyc(); cyc(); #2;
        check("t4_perr_sticky", proto_err, 1'b1);

        rst = 1'b1;
        #1;
        check("t4_rst_perr", proto_err, 1'b0);
        cyc();
        rst = 1'b0;

        // Overrun: len=0 with last=0 on beat 1 stays in DATA.
        start_rd(1'b1, mk_ar(32'h0000_4000, 8'd0));
        m1_rready = 1'b1; s_rvalid = 1'b1; s_r = mk_r(64'hD0, 1'b0);
        cyc(); #2;
        check("t5_perr", proto_err, 1'b1);
        check("t5_busy", busy, 1'b1);
        check("t5_grant", grant, 2'b10);
        s_r = mk_r(64'hD1, 1'b1);
        cyc();
        clr();
        #2;
        check("t5_end_busy", busy, 1'b0);
        check("t5_end_perr", proto_err, 1'b1);

        // Asynchronous reset during beat 2 of a len=7 m0 burst.
        start_rd(1'b0, mk_ar(32'h8000_0200, 8'd7));
        m0_rready = 1'b1; s_rvalid = 1'b1; s_r = mk_r(64'hE0, 1'b0);
        cyc();
        s_r = mk_r(64'hE1, 1'b0);
        #2;
        check("t6_pre_rvalid", m0_rvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_m0_rvalid", m0_rvalid, 1'b0);
        check("t6_m0_r", m0_r, {R_W{1'b0}});
        check("t6_s_rready", s_rready, 1'b0);
        check("t6_grant", grant, 2'b00);
        check("t6_busy", busy, 1'b0);
        check("t6_perr", proto_err, 1'b0);
        cyc();
        rst = 1'b0;
        clr();
        cyc();
        m1_ar = mk_ar(32'h0000_5000, 8'd0); m1_arvalid = 1'b1;
        cyc(); #2;
        check("t6_new_grant", grant, 2'b10);
        check("t6_new_s_arvalid", s_arvalid, 1'b1);
        check("t6_new_s_ar", s_ar, mk_ar(32'h0000_5000, 8'd0));
        s_arready = 1'b1;
        cyc();
        clr();
        m1_rready = 1'b1; s_rvalid = 1'b1; s_r = mk_r(64'hF0, 1'b1);
        #2;
        check("t6_new_m1_rvalid", m1_rvalid, 1'b1);
        cyc();
        clr();
        #2;
        check("t6_new_end_busy", busy, 1'b0);

        // Both masters request continuously for six transactions.
`ifdef AXI_RD_ARB_RR_EN
        rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
        rr_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m0_ar = mk_ar(32'h0000_6000, 8'd0); m1_ar = mk_ar(32'h0000_7000, 8'd0);
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1; s_rvalid = 1'b1; s_r = mk_r(64'h77, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(); #2;
            check($sformatf("t7_grant_%0d", i), grant, rr_exp[i]);
            cyc();
            cyc();
        end
        clr();
        #2;
        check("t7_perr", proto_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
